simon_judge: RTL and testbench
==============================

Name: simon_judge

Overview:
- Game-logic end of the ready/set/go display interface. It produces the `go`-driven sequence playback and the 2-bit `correct` verdict code that the countdown/score display consumes.
- On a start request it replays a pseudo-random symbol sequence of the current round length on the lamps. It then checks the player's button presses against that sequence and emits correct/wrong verdicts.
- Round length grows by one after each completed round, up to `MAX_LEN`.

Parameters:
- SEED, 8'hA5, nonzero initial LFSR state; the sequence restarts from it every round.
- MAX_LEN, 16, final round length; completing it means the game is won.
- SHOW_CYC, 25_000_000, clk cycles each symbol is lit during playback.
- GAP_CYC, 12_500_000, dark clk cycles after each lit symbol.
- TIMEOUT, 300_000_000, idle clk cycles allowed in the input phase before a miss.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  start/continue request from the countdown block; acts on its rising edge only.
- btn  input  4  debounced single-cycle press pulses, one-hot; btn[k] means symbol k.
- show_valid  output  1  a playback lamp is lit.
- show_sym  output  2  symbol being shown; 0 whenever show_valid=0.
- in_ready  output  1  input phase active; presses are judged.
- correct  output  2  verdict: 00 none, 01 correct press (1-cycle pulse), 10 wrong/timeout (held), 11 game won (held).
- round_len  output  5  current round length, 1..MAX_LEN.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, LFSR=SEED, round_len=1, all other outputs 0, go edge register=0.
- LFSR: Fibonacci, fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0],fb}. Current symbol = l[1:0]. Steps once per symbol shown or accepted.
- States: IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, FAIL, WIN.
- IDLE: a go rising edge sets LFSR=SEED, idx=0 and moves to SHOW_ON.
- FAIL / WIN: a go rising edge sets round_len=1, LFSR=SEED, idx=0, correct=00, and moves to SHOW_ON.
- SHOW_ON: show_valid=1 and show_sym=l[1:0] for exactly SHOW_CYC cycles. Then go to SHOW_OFF and step the LFSR.
- SHOW_OFF: GAP_CYC dark cycles, then idx++.
  - If idx == round_len, set LFSR=SEED, idx=0 and go to WAIT_IN.
  - Otherwise go to SHOW_ON.
- WAIT_IN: in_ready=1; the timeout counter clears on entry and on every press.
  - btn == one-hot of l[1:0]: correct=01 for one cycle (registered, the cycle after the btn cycle), LFSR steps, idx++.
  - If that press made idx == round_len:
    - round_len < MAX_LEN: round_len++, in_ready drops, state IDLE (awaits next go).
    - round_len == MAX_LEN: state WIN, correct=11 held.
  - btn nonzero and mismatched, including multi-hot: correct=10 held, state FAIL.
  - Counter reaches TIMEOUT with no press: correct=10, state FAIL.
- btn is ignored outside WAIT_IN. go edges are ignored in SHOW_ON, SHOW_OFF and WAIT_IN.
- The go edge detector samples each cycle. A go held high across FAIL does not retrigger; a new rising edge is required.
- Async reset mid-round aborts immediately to reset values.
- Outputs are registered; there are no combinational paths from btn or go.

Test Plan:
- Bench parameters: SEED=A5, MAX_LEN=3, SHOW_CYC=4, GAP_CYC=2, TIMEOUT=20.
- Reset low, then release; pulse go -> next cycle show_valid=1 and show_sym=01 for 4 cycles, then 2 dark cycles, then in_ready=1 with round_len=1.
- Round 1: btn=0010 -> correct=01 for one cycle; in_ready=0, round_len=2, state IDLE.
- Round 2 after go edge: playback shows 01 then 10. Press 0010 then 0100 -> two correct=01 pulses; round_len=3.
- Round 3: playback shows 01,10,01. Press 0010,0100,0001 (wrong third) -> 01, 01, then correct=10 held. A new go edge -> round_len=1 and playback restarts at symbol 01.
- Complete all three rounds correctly -> correct=11 held after the last press; show_valid=0 and in_ready=0.
- Timeout and reset cases:
  - Enter WAIT_IN and give no press for 20 cycles -> correct=10.
  - Separately, assert reset mid-SHOW_ON -> show_valid=0 and round_len=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/simon_judge.sv
// Memory-game judge: plays back an LFSR symbol sequence on the lamps, then
// checks the player's button presses against it and emits verdict codes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a go rising edge to play the current round
// SHOW_ON  | lamp lit with the current symbol for SHOW_CYC cycles
// SHOW_OFF | dark gap of GAP_CYC cycles between symbols
// WAIT_IN  | judging presses; timeout counter running
// FAIL     | wrong press or timeout; verdict 10 held until go edge
// WIN      | final round completed; verdict 11 held until go edge
module simon_judge #(
  parameter logic [7:0]  SEED     = 8'hA5,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned SHOW_CYC = 25_000_000,
  parameter int unsigned GAP_CYC  = 12_500_000,
  parameter int unsigned TIMEOUT  = 300_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [3:0] btn,
  output logic       show_valid,
  output logic [1:0] show_sym,
  output logic       in_ready,
  output logic [1:0] correct,
  output logic [4:0] round_len
);

  localparam int unsigned MAX_A = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int unsigned MAX_B = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int          CW    = $clog2(MAX_B + 1);

  localparam logic [CW-1:0] SHOW_LD   = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TMO_LD    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [4:0]    MAX_LEN_W = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW_ON  = 3'd1,
    SHOW_OFF = 3'd2,
    WAIT_IN  = 3'd3,
    FAIL     = 3'd4,
    WIN      = 3'd5
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [4:0]    idx;
  logic [CW-1:0] cnt;
  logic          go_q;

  logic          go_rise;
  logic [3:0]    sym_hot;
  logic [4:0]    idx_inc;
  logic [7:0]    lfsr_step;

  assign go_rise   = go & ~go_q;
  assign sym_hot   = 4'b0001 << lfsr[1:0];
  assign idx_inc   = idx + 5'd1;
  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      idx        <= 5'd0;
      cnt        <= CNT_ZERO;
      go_q       <= 1'b0;
      show_valid <= 1'b0;
      show_sym   <= 2'b00;
      in_ready   <= 1'b0;
      correct    <= 2'b00;
      round_len  <= 5'd1;
    end else begin
      go_q <= go;
      // the correct-press code is a single-cycle pulse; 10/11 stay held
      if (correct == 2'b01) correct <= 2'b00;

      case (state)
        IDLE: begin
          if (go_rise) begin
            lfsr       <= SEED;
            idx        <= 5'd0;
            cnt        <= SHOW_LD;
            show_valid <= 1'b1;
            show_sym   <= SEED[1:0];
            state      <= SHOW_ON;
          end
        end

        FAIL, WIN: begin
          if (go_rise) begin
            round_len  <= 5'd1;
            correct    <= 2'b00;
            lfsr       <= SEED;
            idx        <= 5'd0;
            cnt        <= SHOW_LD;
            show_valid <= 1'b1;
            show_sym   <= SEED[1:0];
            state      <= SHOW_ON;
          end
        end

        SHOW_ON: begin
          if (cnt == CNT_ZERO) begin
            show_valid <= 1'b0;
            show_sym   <= 2'b00;
            lfsr       <= lfsr_step;
            cnt        <= GAP_LD;
            state      <= SHOW_OFF;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        SHOW_OFF: begin
          if (cnt == CNT_ZERO) begin
            if (idx_inc == round_len) begin
              // playback done: rewind the sequence for judging
              lfsr     <= SEED;
              idx      <= 5'd0;
              cnt      <= TMO_LD;
              in_ready <= 1'b1;
              state    <= WAIT_IN;
            end else begin
              idx        <= idx_inc;
              cnt        <= SHOW_LD;
              show_valid <= 1'b1;
              show_sym   <= lfsr[1:0];
              state      <= SHOW_ON;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        WAIT_IN: begin
          if (btn == sym_hot) begin
            lfsr <= lfsr_step;
            idx  <= idx_inc;
            cnt  <= TMO_LD;
            if (idx_inc == round_len) begin
              in_ready <= 1'b0;
              if (round_len == MAX_LEN_W) begin
                correct <= 2'b11;
                state   <= WIN;
              end else begin
                correct   <= 2'b01;
                round_len <= round_len + 5'd1;
                state     <= IDLE;
              end
            end else begin
              correct <= 2'b01;
            end
          end else if (btn != 4'b0000) begin
            correct  <= 2'b10;
            in_ready <= 1'b0;
            state    <= FAIL;
          end else if (cnt == CNT_ZERO) begin
            correct  <= 2'b10;
            in_ready <= 1'b0;
            state    <= FAIL;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          show_valid <= 1'b0;
          show_sym   <= 2'b00;
          in_ready   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_judge.sv
// Bench for simon_judge: scoreboard of expected lamp symbols and verdicts,
// plus direct checks of timing, holds, timeout and asynchronous reset.
module tb_simon_judge;

  localparam logic [7:0] SEED     = 8'hA5;
  localparam int         MAX_LEN  = 3;
  localparam int         SHOW_CYC = 4;
  localparam int         GAP_CYC  = 2;
  localparam int         TIMEOUT  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [3:0] btn;
  logic       show_valid;
  logic [1:0] show_sym;
  logic       in_ready;
  logic [1:0] correct;
  logic [4:0] round_len;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [1:0] exp_sym [3] = '{2'd1, 2'd2, 2'd1};

  always #5 clk = ~clk;

  simon_judge #(
    .SEED(SEED), .MAX_LEN(MAX_LEN), .SHOW_CYC(SHOW_CYC),
    .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .btn(btn),
    .show_valid(show_valid), .show_sym(show_sym), .in_ready(in_ready),
    .correct(correct), .round_len(round_len)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_check(input logic [7:0] obs);
    logic [7:0] e;
    if (sb.size() == 0) begin
      check("sb_extra", obs, 8'hFF);
    end else begin
      e = sb.pop_front();
      check("sb_event", obs, e);
    end
  endtask

  // event codes: 1x = lamp lit with symbol x, 2x = verdict x
  logic       sv_q;
  logic [1:0] cor_q;
  always @(negedge clk) begin
    if (!reset) begin
      sv_q  = 1'b0;
      cor_q = 2'b00;
    end else begin
      if (show_valid && !sv_q) sb_check({4'h1, 2'b00, show_sym});
      if (!show_valid) check("sym_dark", show_sym, 2'b00);
      if (correct != 2'b00 && correct != cor_q) sb_check({4'h2, 2'b00, correct});
      sv_q  = show_valid;
      cor_q = correct;
    end
  end

  task automatic push_shows(input int n);
    for (int i = 0; i < n; i++) sb.push_back({4'h1, 2'b00, exp_sym[i]});
  endtask

  task automatic go_pulse();
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int n = 0; n < 200; n++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    check(tag, in_ready, 1'b1);
  endtask

  task automatic press(input logic [3:0] b, input logic [1:0] verdict);
    sb.push_back({4'h2, 2'b00, verdict});
    btn = b;
    @(negedge clk);
    btn = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b0;
    go    = 1'b0;
    btn   = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_show_valid", show_valid, 1'b0);
    check("rst_show_sym",   show_sym,   2'b00);
    check("rst_in_ready",   in_ready,   1'b0);
    check("rst_correct",    correct,    2'b00);
    check("rst_round_len",  round_len,  5'd1);
    reset = 1'b1;
    @(negedge clk);

    // round 1 with playback timing
    push_shows(1);
    go_pulse();
    check("first_show_valid", show_valid, 1'b1);
    check("first_show_sym",   show_sym,   2'd1);
    n = 0;
    while (show_valid && n < 50) begin n++; @(negedge clk); end
    check("lit_cycles", n, SHOW_CYC);
    n = 0;
    while (!in_ready && !show_valid && n < 50) begin n++; @(negedge clk); end
    check("dark_cycles", n, GAP_CYC);
    check("r1_in_ready", in_ready, 1'b1);
    check("r1_round_len", round_len, 5'd1);
    press(4'b0010, 2'b01);
    check("r1_done_ready", in_ready, 1'b0);
    check("r1_done_len", round_len, 5'd2);

    // round 2, with a press during playback that must be ignored
    push_shows(2);
    go_pulse();
    btn = 4'b0001;
    @(negedge clk);
    btn = 4'b0000;
    wait_ready("r2_ready");
    press(4'b0010, 2'b01);
    press(4'b0100, 2'b01);
    check("r2_done_len", round_len, 5'd3);

    // round 3 fails; go is raised during input and held through FAIL
    push_shows(3);
    go_pulse();
    wait_ready("r3_ready");
    press(4'b0010, 2'b01);
    press(4'b0100, 2'b01);
    go = 1'b1;
    @(negedge clk);
    press(4'b0001, 2'b10);
    repeat (5) @(negedge clk);
    check("fail_held", correct, 2'b10);
    check("fail_no_retrig", show_valid, 1'b0);
    check("fail_ready", in_ready, 1'b0);

    // restart and win the whole game
    push_shows(1);
    go_pulse();
    check("restart_len", round_len, 5'd1);
    check("restart_sym", show_sym, 2'd1);
    check("restart_verdict", correct, 2'b00);
    wait_ready("g1_ready");
    press(4'b0010, 2'b01);
    push_shows(2);
    go_pulse();
    wait_ready("g2_ready");
    press(4'b0010, 2'b01);
    press(4'b0100, 2'b01);
    push_shows(3);
    go_pulse();
    wait_ready("g3_ready");
    press(4'b0010, 2'b01);
    press(4'b0100, 2'b01);
    press(4'b0010, 2'b11);
    repeat (5) @(negedge clk);
    check("win_held", correct, 2'b11);
    check("win_show_valid", show_valid, 1'b0);
    check("win_in_ready", in_ready, 1'b0);
    check("win_round_len", round_len, 5'd3);

    // timeout in WAIT_IN
    push_shows(1);
    go_pulse();
    check("tmo_len", round_len, 5'd1);
    wait_ready("tmo_ready");
    sb.push_back({4'h2, 2'b00, 2'b10});
    n = 0;
    while (correct != 2'b10 && n < 100) begin n++; @(negedge clk); end
    check("timeout_cycles", n, TIMEOUT);
    check("tmo_in_ready", in_ready, 1'b0);

    // asynchronous reset during SHOW_ON of round 2
    push_shows(1);
    go_pulse();
    wait_ready("ar_ready");
    press(4'b0010, 2'b01);
    sb.push_back({4'h1, 2'b00, exp_sym[0]});
    go_pulse();
    @(negedge clk);
    check("pre_rst_show", show_valid, 1'b1);
    check("pre_rst_len", round_len, 5'd2);
    #2 reset = 1'b0;
    #1;
    check("async_show_valid", show_valid, 1'b0);
    check("async_round_len", round_len, 5'd1);
    check("async_show_sym", show_sym, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", show_valid, 1'b0);
    check("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
